// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC owner, single-outstanding imem requests, IF/ID output registers
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_next_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pcn_q, hold_pcn_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcn_q, pcn_d;
    logic        vld_q, vld_d;

    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pcn;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_instr_q <= '0;
            hold_pcn_q   <= '0;
            instr_q      <= NOP_INSTR;
            pcn_q        <= '0;
            vld_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pcn_q   <= hold_pcn_d;
            instr_q      <= instr_d;
            pcn_q        <= pcn_d;
            vld_q        <= vld_d;
        end
    end

    // A redirect with a request still in flight must swallow that response in DRAIN.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            case (state_q)
                S_WAIT,
                S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  if (imem_rvalid) state_d = stall ? S_HOLD : S_FETCH;
                S_HOLD:  if (!stall) state_d = S_FETCH;
                S_DRAIN: if (imem_rvalid) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pcn_d    = hold_pcn_q;
        instr_d       = instr_q;
        pcn_d         = pcn_q;
        vld_d         = vld_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pcn   = pc_plus4;

        if (redirect) begin
            pc_d         = redirect_pc & 32'hFFFF_FFFC;
            hold_instr_d = '0;
            hold_pcn_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            hold_pcn_d   = pc_plus4;
                        end else begin
                            deliver = 1'b1;
                            pc_d    = pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        deliver       = 1'b1;
                        deliver_instr = hold_instr_q;
                        deliver_pcn   = hold_pcn_q;
                        pc_d          = pc_plus4;
                    end
                end
                default: ;
            endcase
        end

        // In DRAIN the redirect leaves the outputs to the normal stall/bubble rules.
        if (redirect && (state_q != S_DRAIN)) begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
        end else if (!stall) begin
            if (deliver) begin
                instr_d = deliver_instr;
                pcn_d   = deliver_pcn;
                vld_d   = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                vld_d   = 1'b0;
            end
        end
    end

    always_comb begin
        imem_req  = rst_n && (state_q == S_FETCH) && !redirect;
        imem_addr = pc_q;
    end

    assign instruction_out = instr_q;
    assign pc_next_out     = pcn_q;
    assign valid_out       = vld_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a variable-latency memory model
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcn;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction_out;
    logic [31:0] pc_next_out;
    logic        valid_out;

    int total = 0;
    int bad = 0;
    int n_del = 0;

    item_t       sb_q[$];
    logic [31:0] exp_addr = RPC;
    logic        exp_valid = 1'b0;
    logic        exp_new = 1'b0;
    bit          out_pend = 1'b0;
    int          gen = 0;
    int          out_gen = 0;
    bit          mem_busy = 1'b0;
    int          mem_rem = 0;
    logic [31:0] mem_addr = '0;
    int          lat_fixed = 1;
    bit          req_seen = 1'b0;
    logic        rst_drive = 1'b1;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instruction_out(instruction_out),
        .pc_next_out(pc_next_out),
        .valid_out(valid_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_addr  = RPC;
        exp_valid = 1'b0;
        exp_new   = 1'b0;
        out_pend  = 1'b0;
        mem_busy  = 1'b0;
        gen++;
    endtask

    // Reference for the coming clock edge: one request in flight, responses
    // after the latest redirect are discarded, a stalled response waits.
    task automatic model_step();
        logic  exp_req;
        logic  drain_before;
        item_t it;
        exp_new = 1'b0;
        exp_req = rst_n && !out_pend && (sb_q.size() == 0) && !redirect;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (!rst_n) begin
            exp_valid = 1'b0;
            return;
        end
        if (imem_req)
            chk("imem_addr", imem_addr, exp_addr);
        drain_before = out_pend && (out_gen != gen);
        if (imem_rvalid && out_pend) begin
            if ((out_gen == gen) && !redirect) begin
                it.instr = exp_addr ^ KEY;
                it.pcn   = exp_addr + 32'd4;
                sb_q.push_back(it);
                exp_addr = exp_addr + 32'd4;
            end
            out_pend = 1'b0;
        end
        exp_new = !redirect && !stall && (sb_q.size() > 0);
        if (redirect) begin
            sb_q.delete();
            gen++;
            exp_addr = {redirect_pc[31:2], 2'b00};
            if (!drain_before || !stall)
                exp_valid = 1'b0;
        end else if (!stall) begin
            exp_valid = exp_new;
        end
        if (imem_req) begin
            out_pend = 1'b1;
            out_gen  = gen;
            req_seen = 1'b1;
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_rem  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        end
    endtask

    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        rst_n       = rst_drive;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (mem_busy && rst_n) begin
            mem_rem--;
            if (mem_rem == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ KEY;
                mem_busy    = 1'b0;
            end
        end
        #1;
        model_step();
    endtask

    task automatic wait_req(input int lat);
        lat_fixed = lat;
        req_seen  = 1'b0;
        for (int i = 0; i < 20 && !req_seen; i++)
            cycle(1'b0, 1'b0, '0);
        chk("req_seen", 32'(req_seen), 32'd1);
        lat_fixed = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_instr", instruction_out, NOP);
        chk("rst_pcn", pc_next_out, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
    endtask

    always @(negedge clk) begin
        item_t it;
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        if (exp_new) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_pop: got empty queue want one item at %0t", $time);
            end else begin
                it = sb_q.pop_front();
                chk("instruction_out", instruction_out, it.instr);
                chk("pc_next_out", pc_next_out, it.pcn);
                n_del++;
            end
        end else if (!exp_valid) begin
            chk("bubble_instr", instruction_out, NOP);
        end
    end

    initial begin
        bit          st;
        bit          rd;
        logic [31:0] tgt;

        #2 rst_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        rst_drive = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, '0);

        // L=1 streaming, then a 3-cycle stall spanning the response for addr 8
        rst_drive = 1'b1;
        lat_fixed = 1;
        for (int i = 0; i < 14; i++)
            cycle((i >= 4) && (i <= 6), 1'b0, '0);

        // redirect in WAIT, stale response two cycles later
        wait_req(3);
        cycle(1'b0, 1'b1, 32'h0000_0100);
        lat_fixed = 1;
        repeat (8) cycle(1'b0, 1'b0, '0);

        // redirect coinciding with the response
        wait_req(2);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0200);
        lat_fixed = 1;
        repeat (6) cycle(1'b0, 1'b0, '0);

        // unaligned target at the top of the address space wraps to 0
        wait_req(1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
        lat_fixed = 1;
        repeat (8) cycle(1'b0, 1'b0, '0);

        // asynchronous reset while waiting under stall
        wait_req(4);
        cycle(1'b1, 1'b0, '0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        rst_drive = 1'b0;
        #1 check_reset_values();
        model_reset();
        repeat (2) cycle(1'b0, 1'b0, '0);
        rst_drive = 1'b1;
        lat_fixed = 1;
        repeat (6) cycle(1'b0, 1'b0, '0);

        lat_fixed = 0;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 4);
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
            cycle(st, rd, tgt);
        end
        repeat (10) cycle(1'b0, 1'b0, '0);

        chk("min_deliveries", 32'(n_del >= 300), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
